alu_pipe_gen2: RTL and testbench

- Second-generation parametrised ALU. Generalises the 8-bit ALU to DW-bit operands.
- Adds an explicit operand-capture FSM with a parametrised timeout, a 2-stage multiply pipeline, and OUT_VALID/BUSY handshaking.
- All outputs are driven to defined values; none are ever high-Z.
- Sits between the operand/command sequencer and the result scoreboard in the ALU subsystem.

---
 rtl/alu_pipe_gen2_if.sv | 34 +++
 rtl/alu_pipe_gen2.sv | 376 +++++++++++++++++++++++++++++++++++++
 tb/tb_alu_pipe_gen2.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_gen2_if.sv
// alu_pipe_gen2_if: operand/command beat and result/flag bundle for alu_pipe_gen2.
// The master side is the operand sequencer. The slave side is the ALU.

interface alu_pipe_gen2_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 4
);
    logic            ce;
    logic            mode;
    logic [CW-1:0]   cmd;
    logic [1:0]      inp_valid;
    logic [DW-1:0]   opa;
    logic [DW-1:0]   opb;
    logic            cin;
    logic [2*DW-1:0] res;
    logic            out_valid;
    logic            busy;
    logic            cout;
    logic            oflow;
    logic            g;
    logic            e;
    logic            l;
    logic            err;

    modport master (
        output ce, mode, cmd, inp_valid, opa, opb, cin,
        input  res, out_valid, busy, cout, oflow, g, e, l, err
    );

    modport slave (
        input  ce, mode, cmd, inp_valid, opa, opb, cin,
        output res, out_valid, busy, cout, oflow, g, e, l, err
    );
endinterface

// File: rtl/alu_pipe_gen2.sv
// alu_pipe_gen2: DW-bit ALU with a split-operand capture FSM, idle timeout,
// a 2-stage multiply pipeline and OUT_VALID/BUSY handshaking.
// Optional feature macro: ALU_SIGNED_EN (two's-complement arithmetic in MODE=1).

module alu_pipe_gen2 #(
    parameter int unsigned DW      = 8,
    parameter int unsigned CW      = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    alu_pipe_gen2_if.slave bus
);

    localparam int unsigned SW   = $clog2(DW);
    localparam int unsigned RW   = 2 * DW;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

`ifdef ALU_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StWaitA,
        StWaitB,
        StMul2
    } state_e;

    // Result placement helpers.
    function automatic logic [RW-1:0] zext_w(input logic [DW:0] x);
        return {{(RW-DW-1){1'b0}}, x};
    endfunction

    function automatic logic [RW-1:0] zext_d(input logic [DW-1:0] x);
        return {{DW{1'b0}}, x};
    endfunction

    function automatic logic [RW-1:0] sext_d(input logic [DW-1:0] x);
        return {{DW{x[DW-1]}}, x};
    endfunction

    // DW+1-bit multiply intermediate; sign bit only replicated in signed builds.
    function automatic logic [DW:0] ext1(input logic [DW-1:0] x);
        return {SignedEn & x[DW-1], x};
    endfunction

    function automatic logic ovf_add(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic ovf_sub(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    state_e          state_q, state_d;
    logic [DW-1:0]   a_q, b_q;
    logic [CntW-1:0] cnt_q;
    logic [DW:0]     mul_a_q, mul_b_q;
    logic [RW-1:0]   res_q;
    logic            out_valid_q;
    logic            cout_q, oflow_q, g_q, e_q, l_q, err_q;

    // FSM controls
    logic launch, cap_a, cap_b, cnt_clr, cnt_inc, timeout, mul_fire;

    // Operands as seen by the launching beat: fresh beat data wins over held data.
    logic [DW-1:0] a_eff, b_eff;
    logic [31:0]   op;

    logic [DW:0] add_ab, add_abc, sub_ab, sub_abc, inc_a, dec_a, inc_b, dec_b;
    logic [DW:0] arith_r;
    logic        arith_sa, arith_sb, arith_add;

    logic [SW-1:0] rot_amt;
    logic [DW-1:0] rot_l, rot_r, logic_v;
    logic          rot_err;

    logic [RW-1:0] alu_res;
    logic          alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err, alu_is_mul;
    logic [DW:0]   alu_ma, alu_mb;

    logic [RW-1:0] mul_x, mul_y, prod;

    assign a_eff = bus.inp_valid[0] ? bus.opa : a_q;
    assign b_eff = bus.inp_valid[1] ? bus.opb : b_q;
    // The CMD of the launching beat always decides the op, so the first beat's CMD is not kept.
    assign op    = 32'(bus.cmd);

    localparam logic [DW:0] One = {{DW{1'b0}}, 1'b1};

    assign add_ab  = {1'b0, a_eff} + {1'b0, b_eff};
    assign add_abc = add_ab + {{DW{1'b0}}, bus.cin};
    assign sub_ab  = {1'b0, a_eff} - {1'b0, b_eff};
    assign sub_abc = sub_ab - {{DW{1'b0}}, bus.cin};
    assign inc_a   = {1'b0, a_eff} + One;
    assign dec_a   = {1'b0, a_eff} - One;
    assign inc_b   = {1'b0, b_eff} + One;
    assign dec_b   = {1'b0, b_eff} - One;

    assign rot_amt = b_eff[SW-1:0];
    assign rot_l   = (a_eff << rot_amt) | (a_eff >> (DW - 32'(rot_amt)));
    assign rot_r   = (a_eff >> rot_amt) | (a_eff << (DW - 32'(rot_amt)));
    assign rot_err = |b_eff[DW-1:SW];

    // Stage 2 multiply; truncating to RW bits keeps the low product bits exact.
    assign mul_x = SignedEn ? {{(RW-DW-1){mul_a_q[DW]}}, mul_a_q}
                            : {{(RW-DW-1){1'b0}}, mul_a_q};
    assign mul_y = SignedEn ? {{(RW-DW-1){mul_b_q[DW]}}, mul_b_q}
                            : {{(RW-DW-1){1'b0}}, mul_b_q};
    assign prod  = mul_x * mul_y;

    // State register; CE low freezes the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (bus.ce) begin
            state_q <= state_d;
        end
    end

    // Next-state and beat-capture decode.
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        cap_a    = 1'b0;
        cap_b    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        timeout  = 1'b0;
        mul_fire = 1'b0;
        unique case (state_q)
            StIdle: begin
                cap_a = bus.inp_valid[0];
                cap_b = bus.inp_valid[1];
                unique case (bus.inp_valid)
                    2'b11: launch = 1'b1;
                    2'b01: begin
                        cnt_clr = 1'b1;
                        state_d = StWaitB;
                    end
                    2'b10: begin
                        cnt_clr = 1'b1;
                        state_d = StWaitA;
                    end
                    default: ;
                endcase
            end
            StWaitB: begin
                if (bus.inp_valid[1]) begin
                    cap_a   = bus.inp_valid[0];
                    cap_b   = 1'b1;
                    launch  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = StIdle;
                end else if (bus.inp_valid[0]) begin
                    cap_a   = 1'b1;
                    cnt_clr = 1'b1;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            StWaitA: begin
                if (bus.inp_valid[0]) begin
                    cap_a   = 1'b1;
                    cap_b   = bus.inp_valid[1];
                    launch  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = StIdle;
                end else if (bus.inp_valid[1]) begin
                    cap_b   = 1'b1;
                    cnt_clr = 1'b1;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            StMul2: begin
                // Beats are ignored here; the product lands on this edge.
                mul_fire = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (launch && alu_is_mul) begin
            state_d = StMul2;
        end
    end

    // Pick the add/sub sub-result and the operand signs used for overflow.
    always_comb begin
        arith_r   = add_ab;
        arith_sa  = a_eff[DW-1];
        arith_sb  = b_eff[DW-1];
        arith_add = 1'b1;
        case (op)
            1: begin
                arith_r   = sub_ab;
                arith_add = 1'b0;
            end
            2: arith_r = add_abc;
            3: begin
                arith_r   = sub_abc;
                arith_add = 1'b0;
            end
            4: begin
                arith_r  = inc_a;
                arith_sb = 1'b0;
            end
            5: begin
                arith_r   = dec_a;
                arith_sb  = 1'b0;
                arith_add = 1'b0;
            end
            6: begin
                arith_r  = inc_b;
                arith_sa = b_eff[DW-1];
                arith_sb = 1'b0;
            end
            7: begin
                arith_r   = dec_b;
                arith_sa  = b_eff[DW-1];
                arith_sb  = 1'b0;
                arith_add = 1'b0;
            end
            default: ;
        endcase
    end

    // Single-cycle result, flags and multiply-stage operands for the launching beat.
    always_comb begin
        alu_res    = '0;
        alu_cout   = 1'b0;
        alu_oflow  = 1'b0;
        alu_g      = 1'b0;
        alu_e      = 1'b0;
        alu_l      = 1'b0;
        alu_err    = 1'b0;
        alu_is_mul = 1'b0;
        alu_ma     = '0;
        alu_mb     = '0;
        logic_v    = '0;
        if (bus.mode) begin
            case (op)
                0, 1, 2, 3, 4, 5, 6, 7: begin
                    if (SignedEn) begin
                        alu_res   = sext_d(arith_r[DW-1:0]);
                        alu_oflow = arith_add ? ovf_add(arith_sa, arith_sb, arith_r[DW-1])
                                              : ovf_sub(arith_sa, arith_sb, arith_r[DW-1]);
                    end else begin
                        alu_res   = arith_add ? zext_w(arith_r) : zext_d(arith_r[DW-1:0]);
                        alu_oflow = ~arith_add & arith_r[DW];
                    end
                    alu_cout = arith_add & arith_r[DW];
                end
                8: begin
                    if (SignedEn) begin
                        alu_g = $signed(a_eff) > $signed(b_eff);
                        alu_l = $signed(a_eff) < $signed(b_eff);
                    end else begin
                        alu_g = a_eff > b_eff;
                        alu_l = a_eff < b_eff;
                    end
                    alu_e = a_eff == b_eff;
                end
                9: begin
                    alu_is_mul = 1'b1;
                    alu_ma     = ext1(a_eff) + One;
                    alu_mb     = ext1(b_eff) + One;
                end
                10: begin
                    alu_is_mul = 1'b1;
                    alu_ma     = ext1(a_eff) << 1;
                    alu_mb     = ext1(b_eff);
                end
                default: alu_err = 1'b1;
            endcase
        end else begin
            case (op)
                0:  logic_v = a_eff & b_eff;
                1:  logic_v = ~(a_eff & b_eff);
                2:  logic_v = a_eff | b_eff;
                3:  logic_v = ~(a_eff | b_eff);
                4:  logic_v = a_eff ^ b_eff;
                5:  logic_v = ~(a_eff ^ b_eff);
                6:  logic_v = ~a_eff;
                7:  logic_v = ~b_eff;
                8:  logic_v = a_eff >> 1;
                9:  logic_v = a_eff << 1;
                10: logic_v = b_eff >> 1;
                11: logic_v = b_eff << 1;
                12: begin
                    logic_v = rot_l;
                    alu_err = rot_err;
                end
                13: begin
                    logic_v = rot_r;
                    alu_err = rot_err;
                end
                default: alu_err = 1'b1;
            endcase
            alu_res = zext_d(logic_v);
        end
    end

    // Operand holding, idle counter, multiply stage 1 and registered results/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            oflow_q     <= 1'b0;
            g_q         <= 1'b0;
            e_q         <= 1'b0;
            l_q         <= 1'b0;
            err_q       <= 1'b0;
        end else if (bus.ce) begin
            out_valid_q <= 1'b0;
            if (cap_a) a_q <= bus.opa;
            if (cap_b) b_q <= bus.opb;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (launch && alu_is_mul) begin
                mul_a_q <= alu_ma;
                mul_b_q <= alu_mb;
            end
            if (timeout) begin
                res_q       <= '0;
                {cout_q, oflow_q, g_q, e_q, l_q} <= '0;
                err_q       <= 1'b1;
                out_valid_q <= 1'b1;
            end else if (launch && !alu_is_mul) begin
                res_q       <= alu_res;
                cout_q      <= alu_cout;
                oflow_q     <= alu_oflow;
                g_q         <= alu_g;
                e_q         <= alu_e;
                l_q         <= alu_l;
                err_q       <= alu_err;
                out_valid_q <= 1'b1;
            end else if (mul_fire) begin
                res_q       <= prod;
                {cout_q, oflow_q, g_q, e_q, l_q, err_q} <= '0;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign bus.res       = res_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == StMul2);
    assign bus.cout      = cout_q;
    assign bus.oflow     = oflow_q;
    assign bus.g         = g_q;
    assign bus.e         = e_q;
    assign bus.l         = l_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_pipe_gen2.sv
// Bench for alu_pipe_gen2: directed scenarios plus randomized beats, compared
// every cycle against a behavioural reference model.

module tb_alu_pipe_gen2;
    localparam int DW      = 8;
    localparam int CW      = 4;
    localparam int TIMEOUT = 16;
    localparam int M       = 1 << DW;

    typedef struct packed {
        logic [2*DW-1:0] res;
        logic [5:0]      flags;  // {cout, oflow, g, e, l, err}
        logic            mul;
    } result_t;

    logic clk = 1'b0;
    logic rst;

    alu_pipe_gen2_if #(.DW(DW), .CW(CW)) bus ();

    alu_pipe_gen2 #(.DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: which operands are pending, their values, idle run length.
    bit              have_a, have_b, mul_pend;
    int              hold_a, hold_b, idle_cnt;
    result_t         mul_res;
    logic [2*DW-1:0] exp_res;
    logic [5:0]      exp_flags;
    bit              exp_valid, exp_busy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic result_t golden(input bit mode, input int cmd, input int a, input int b,
                                       input int cin);
        result_t r;
        int v;
        int s;
        r = '0;
        v = 0;
        s = b % DW;
        if (mode) begin
            case (cmd)
                0, 2, 4, 6: begin
                    v = (cmd == 0) ? a + b : (cmd == 2) ? a + b + cin : (cmd == 4) ? a + 1 : b + 1;
                    r.res      = v[2*DW-1:0];
                    r.flags[5] = (v >= M);
                end
                1, 3, 5, 7: begin
                    v = (cmd == 1) ? a - b : (cmd == 3) ? a - b - cin : (cmd == 5) ? a - 1 : b - 1;
                    r.flags[4] = (v < 0);
                    v = (v + M) % M;
                    r.res = v[2*DW-1:0];
                end
                8: begin
                    r.flags[3] = (a > b);
                    r.flags[2] = (a == b);
                    r.flags[1] = (a < b);
                end
                9: begin
                    v = ((a + 1) * (b + 1)) % (M * M);
                    r.res = v[2*DW-1:0];
                    r.mul = 1'b1;
                end
                10: begin
                    v = (2 * a * b) % (M * M);
                    r.res = v[2*DW-1:0];
                    r.mul = 1'b1;
                end
                default: r.flags[0] = 1'b1;
            endcase
        end else begin
            case (cmd)
                0:  v = a & b;
                1:  v = ~(a & b);
                2:  v = a | b;
                3:  v = ~(a | b);
                4:  v = a ^ b;
                5:  v = ~(a ^ b);
                6:  v = ~a;
                7:  v = ~b;
                8:  v = a >> 1;
                9:  v = a << 1;
                10: v = b >> 1;
                11: v = b << 1;
                12: begin
                    v = (a << s) | (a >> (DW - s));
                    r.flags[0] = (b >= DW);
                end
                13: begin
                    v = (a >> s) | (a << (DW - s));
                    r.flags[0] = (b >= DW);
                end
                default: r.flags[0] = 1'b1;
            endcase
            v = v & (M - 1);
            r.res = v[2*DW-1:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        have_a    = 0;
        have_b    = 0;
        mul_pend  = 0;
        hold_a    = 0;
        hold_b    = 0;
        idle_cnt  = 0;
        exp_res   = '0;
        exp_flags = '0;
        exp_valid = 0;
        exp_busy  = 0;
    endtask

    task automatic model_step(input bit ce, input bit mode, input int cmd, input logic [1:0] iv,
                              input int a, input int b, input int cin);
        result_t r;
        if (!ce) return;
        exp_valid = 0;
        if (mul_pend) begin
            mul_pend  = 0;
            exp_res   = mul_res.res;
            exp_flags = mul_res.flags;
            exp_valid = 1;
        end else if (iv == 2'b00) begin
            if (have_a || have_b) begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT) begin
                    have_a    = 0;
                    have_b    = 0;
                    idle_cnt  = 0;
                    exp_res   = '0;
                    exp_flags = 6'b000001;
                    exp_valid = 1;
                end
            end
        end else begin
            if (iv[0]) begin
                hold_a = a;
                have_a = 1;
            end
            if (iv[1]) begin
                hold_b = b;
                have_b = 1;
            end
            idle_cnt = 0;
            if (have_a && have_b) begin
                have_a = 0;
                have_b = 0;
                r = golden(mode, cmd, hold_a, hold_b, cin);
                if (r.mul) begin
                    mul_pend = 1;
                    mul_res  = r;
                end else begin
                    exp_res   = r.res;
                    exp_flags = r.flags;
                    exp_valid = 1;
                end
            end
        end
        exp_busy = mul_pend;
    endtask

    task automatic check_outputs();
        check_eq("out_valid", bus.out_valid, exp_valid);
        check_eq("busy", bus.busy, exp_busy);
        check_eq("res", bus.res, exp_res);
        check_eq("flags", {bus.cout, bus.oflow, bus.g, bus.e, bus.l, bus.err}, exp_flags);
    endtask

    task automatic cycle(input bit ce, input bit mode, input int cmd, input logic [1:0] iv,
                         input int a, input int b, input bit cin);
        bus.ce        = ce;
        bus.mode      = mode;
        bus.cmd       = cmd[CW-1:0];
        bus.inp_valid = iv;
        bus.opa       = a[DW-1:0];
        bus.opb       = b[DW-1:0];
        bus.cin       = cin;
        @(posedge clk);
        model_step(ce, mode, cmd, iv, a, b, int'(cin));
        #1;
        check_outputs();
    endtask

    function automatic int rnd_op();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return 0;
        if (k == 1) return M - 1;
        return $urandom_range(0, M - 1);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit         r_ce;
        bit         r_mode;
        bit         r_cin;
        int         r_cmd;
        logic [1:0] r_iv;

        rst           = 1'b1;
        bus.ce        = 1'b1;
        bus.mode      = 1'b0;
        bus.cmd       = '0;
        bus.inp_valid = 2'b00;
        bus.opa       = '0;
        bus.opb       = '0;
        bus.cin       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Add with carry out.
        cycle(1, 1, 0, 2'b11, 8'hFF, 8'h01, 0);
        check_eq("tp1_res", bus.res, 16'h0100);
        check_eq("tp1_cout", bus.cout, 1);
        check_eq("tp1_err", bus.err, 0);

        // Split operands with idle gap.
        cycle(1, 1, 1, 2'b01, 10, 0, 0);
        repeat (3) cycle(1, 1, 1, 2'b00, 0, 0, 0);
        cycle(1, 1, 1, 2'b10, 0, 3, 0);
        check_eq("tp2_valid", bus.out_valid, 1);
        check_eq("tp2_res", bus.res, 7);
        check_eq("tp2_oflow", bus.oflow, 0);

        // Timeout after TIMEOUT idle cycles, then a fresh WAIT_A.
        cycle(1, 1, 0, 2'b01, 5, 0, 0);
        repeat (TIMEOUT - 1) cycle(1, 1, 0, 2'b00, 0, 0, 0);
        check_eq("tp3_early", bus.out_valid, 0);
        cycle(1, 1, 0, 2'b00, 0, 0, 0);
        check_eq("tp3_valid", bus.out_valid, 1);
        check_eq("tp3_err", bus.err, 1);
        check_eq("tp3_res", bus.res, 0);
        cycle(1, 1, 0, 2'b10, 0, 2, 0);
        cycle(1, 1, 0, 2'b01, 6, 0, 0);
        check_eq("tp3_next_res", bus.res, 8);

        // Multiply pipeline; the beat during BUSY is dropped.
        cycle(1, 1, 9, 2'b11, 3, 4, 0);
        check_eq("tp4_busy", bus.busy, 1);
        cycle(1, 1, 0, 2'b11, 50, 60, 0);
        check_eq("tp4_res", bus.res, 20);
        check_eq("tp4_busy_low", bus.busy, 0);
        cycle(1, 1, 0, 2'b00, 0, 0, 0);
        check_eq("tp4_ignored", bus.out_valid, 0);

        // Rotate left, with and without out-of-range shift bits.
        cycle(1, 0, 12, 2'b11, 8'h81, 8'h01, 0);
        check_eq("tp5_res", bus.res, 16'h0003);
        check_eq("tp5_err", bus.err, 0);
        cycle(1, 0, 12, 2'b11, 8'h81, 8'h11, 0);
        check_eq("tp5b_res", bus.res, 16'h0003);
        check_eq("tp5b_err", bus.err, 1);

        // Async reset during MUL2 discards the multiply.
        cycle(1, 1, 10, 2'b11, 7, 9, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 1, 0, 2'b00, 0, 0, 0);
        cycle(1, 1, 0, 2'b00, 0, 0, 0);

        // Randomized beats with periodic idle bursts to reach the timeout.
        for (int i = 0; i < 3000; i++) begin
            r_ce   = ($urandom_range(0, 9) != 0);
            r_mode = 1'($urandom_range(0, 1));
            r_cin  = 1'($urandom_range(0, 1));
            r_cmd  = $urandom_range(0, 15);
            r_iv   = ((i % 200) < 20) ? 2'b00 : 2'($urandom_range(0, 3));
            cycle(r_ce, r_mode, r_cmd, r_iv, rnd_op(), rnd_op(), r_cin);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
